// File: rtl/int_bus_mux_reg_if.sv
// Internal bus mux signal bundle: sources, one-hot select and capture strobe in;
// combinational/registered bus value and conflict status out.
interface int_bus_mux_reg_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_SRC    = 8
);
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_sel;
  logic                          sel_valid;
  logic                          conflict_clr;
  logic [DATA_WIDTH-1:0]         bus_comb;
  logic [DATA_WIDTH-1:0]         bus_out;
  logic                          bus_valid;
  logic                          conflict;
  logic                          conflict_flag;
  logic [7:0]                    conflict_cnt;

  modport master (
    output src_data, src_sel, sel_valid, conflict_clr,
    input  bus_comb, bus_out, bus_valid, conflict, conflict_flag, conflict_cnt
  );

  modport slave (
    input  src_data, src_sel, sel_valid, conflict_clr,
    output bus_comb, bus_out, bus_valid, conflict, conflict_flag, conflict_cnt
  );
endinterface

// File: rtl/int_bus_mux_reg.sv
// Priority bus mux (highest set select wins, source 0 by default) with a registered bus keeper.
// Multi-select conflict detection is built only when INT_BUS_CONFLICT_DET_EN is defined.
module int_bus_mux_reg #(
  parameter int unsigned        DATA_WIDTH  = 16,
  parameter int unsigned        NUM_SRC     = 8,
  parameter logic [NUM_SRC-1:0] NARROW_MASK = '0
) (
  input logic              clk,
  input logic              reset_n,
  int_bus_mux_reg_if.slave bus
);

  // Narrow sources keep only their low byte; DATA_WIDTH must be at least 8.
  localparam logic [DATA_WIDTH-1:0] NarrowKeep = DATA_WIDTH'(8'hFF);

  logic [DATA_WIDTH-1:0] words [NUM_SRC];
  logic [DATA_WIDTH-1:0] sel_word;
  logic [DATA_WIDTH-1:0] bus_out_q;
  logic                  bus_valid_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign words[g] = NARROW_MASK[g] ? (bus.src_data[g*DATA_WIDTH +: DATA_WIDTH] & NarrowKeep)
                                     : bus.src_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    sel_word = words[0];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (bus.src_sel[i]) begin
        sel_word = words[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      bus_valid_q <= bus.sel_valid;
      if (bus.sel_valid) begin
        bus_out_q <= sel_word;
      end
    end
  end

  assign bus.bus_comb  = sel_word;
  assign bus.bus_out   = bus_out_q;
  assign bus.bus_valid = bus_valid_q;

`ifdef INT_BUS_CONFLICT_DET_EN
  logic       multi_sel;
  logic       conflict_q;
  logic       conflict_flag_q;
  logic [7:0] conflict_cnt_q;

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign multi_sel = bus.sel_valid &&
                     ((bus.src_sel & (bus.src_sel - NUM_SRC'(1))) != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q      <= 1'b0;
      conflict_flag_q <= 1'b0;
      conflict_cnt_q  <= 8'h00;
    end else begin
      conflict_q <= multi_sel;
      if (bus.conflict_clr) begin
        conflict_flag_q <= 1'b0;
        conflict_cnt_q  <= 8'h00;
      end else if (multi_sel) begin
        conflict_flag_q <= 1'b1;
        if (conflict_cnt_q != 8'hFF) begin
          conflict_cnt_q <= conflict_cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.conflict      = conflict_q;
  assign bus.conflict_flag = conflict_flag_q;
  assign bus.conflict_cnt  = conflict_cnt_q;
`else
  logic unused_conflict_clr;
  assign unused_conflict_clr = bus.conflict_clr;

  assign bus.conflict      = 1'b0;
  assign bus.conflict_flag = 1'b0;
  assign bus.conflict_cnt  = 8'h00;
`endif

endmodule
